// File: rtl/autotype_pkg.sv
`default_nettype none
// ============================================================================
// Module   : autotype_pkg
// Purpose  : Shared types and constants for the autotype sequencer: the
//            sequencer state encoding, key codes used in the key table, and
//            a helper that packs a list of key codes into the flat SEQ
//            parameter format (entry i at bits [i*KW +: KW]).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package autotype_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  // Key codes: code k (1..N_KEYS) drives key line k-1; 0 is a gap.
  localparam int KEY_NONE  = 0;
  localparam int KEY_ENTER = 1;
  localparam int KEY_B     = 2;
  localparam int KEY_C     = 3;

  localparam int c_MAX_CODES    = 16;
  localparam int c_MAX_SEQ_BITS = 64;

  // Repack up to 16 four-bit codes (codes[0] = first entry) into a flat
  // table of len entries of kw bits each.
  function automatic logic [c_MAX_SEQ_BITS-1:0] pack_seq(
    input logic [c_MAX_CODES-1:0][3:0] codes,
    input int                          len,
    input int                          kw
  );
    logic [c_MAX_SEQ_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < c_MAX_CODES; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ((i < len) && (b < kw)) begin
          r[i*kw + b] = codes[i][b];
        end
      end
    end
    return r;
  endfunction

  // Default table: gap,b,gap,c,gap,enter,gap,enter,gap,gap,gap,enter,gap.
  // Listed from the highest index down to entry 0.
  localparam logic [c_MAX_CODES-1:0][3:0] c_DEFAULT_CODES = {
    4'd0, 4'd0, 4'd0,
    4'(KEY_NONE),  4'(KEY_ENTER), 4'(KEY_NONE), 4'(KEY_NONE),
    4'(KEY_NONE),  4'(KEY_ENTER), 4'(KEY_NONE), 4'(KEY_ENTER),
    4'(KEY_NONE),  4'(KEY_C),     4'(KEY_NONE), 4'(KEY_B),
    4'(KEY_NONE)
  };

  localparam int              c_DEFAULT_SEQ_LEN = 13;
  localparam int              c_DEFAULT_KW      = 2;
  localparam logic [25:0]     c_DEFAULT_SEQ     =
    26'(pack_seq(c_DEFAULT_CODES, c_DEFAULT_SEQ_LEN, c_DEFAULT_KW));

endpackage
`default_nettype wire

// File: rtl/autotype_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : autotype_step_timer
// Purpose  : Loadable down-counter shared by the reset-hold and key-step
//            phases. Counts down to zero and holds there (no wrap).
// Ports    : clk       - clock
//            reset     - synchronous active-high reset (loads RST_VAL)
//            load      - load load_val this cycle (wins over counting)
//            load_val  - value to load (terminal count - 1)
//            tc        - counter is at zero (last cycle of the phase)
//            press_nxt - press window flag for the value held next cycle
// Revision : 1.0 - initial release
// ============================================================================
module autotype_step_timer
  import autotype_pkg::*;
#(
  parameter int CW           = 23,
  parameter int RST_VAL      = 0,
  parameter int PRESS_THRESH = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc,
  output logic          press_nxt
);

  localparam logic [CW-1:0] c_RST_VAL      = CW'(RST_VAL);
  localparam logic [CW-1:0] c_PRESS_THRESH = CW'(PRESS_THRESH);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (load) begin
      w_cnt_nxt = load_val;
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= c_RST_VAL;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign tc = (r_cnt == '0);

  // Counting down from STEP_CYCLES-1, "elapsed < PRESS_CYCLES" is the same
  // as "remaining >= STEP_CYCLES-PRESS_CYCLES". Evaluated on the next value
  // so the registered key outputs line up with the step they belong to.
  assign press_nxt = (w_cnt_nxt >= c_PRESS_THRESH);

endmodule
`default_nettype wire

// File: rtl/autotype_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : autotype_sequencer
// Purpose  : Holds the computer core in reset, then types a programmable key
//            table onto N_KEYS key lines; physical buttons are ORed in.
// Ports    : clk         - clock
//            reset       - synchronous active-high reset
//            start       - one-cycle request to (re)run the sequence
//            btn         - physical buttons, active-high, synchronised
//            sys_reset_n - active-low reset to the core (registered)
//            keys        - key lines to the core, auto | btn (registered)
//            busy        - high in RESET_HOLD and RUN (registered)
//            step        - current table index (registered)
// Options  : AUTOTYPE_BTN_ABORT_EN - a rising edge on any button during
//            RESET_HOLD/RUN abandons the sequence and goes to DONE.
// Revision : 1.0 - initial release
// ============================================================================
module autotype_sequencer
  import autotype_pkg::*;
#(
  parameter int                   N_KEYS       = 3,
  parameter int                   SEQ_LEN      = 13,
  localparam int                  KW           = $clog2(N_KEYS + 1),
  parameter logic [SEQ_LEN*KW-1:0] SEQ         = c_DEFAULT_SEQ,
  parameter int                   STEP_CYCLES  = 8388608,
  parameter int                   PRESS_CYCLES = 8388608,
  parameter int                   RESET_CYCLES = 8388608,
  parameter int                   AUTOSTART    = 1,
  localparam int                  SW           = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_KEYS-1:0] btn,
  output logic              sys_reset_n,
  output logic [N_KEYS-1:0] keys,
  output logic              busy,
  output logic [SW-1:0]     step
);

  localparam int c_MAX_CYC = (STEP_CYCLES > RESET_CYCLES) ? STEP_CYCLES : RESET_CYCLES;
  localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

  localparam logic [c_CNT_W-1:0] c_STEP_LOAD  = c_CNT_W'(STEP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_RESET_LOAD = c_CNT_W'(RESET_CYCLES - 1);
  localparam logic [SW-1:0]      c_LAST_STEP  = SW'(SEQ_LEN - 1);
  localparam state_t             c_RST_STATE  = (AUTOSTART != 0) ? RESET_HOLD : IDLE;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SW-1:0]       r_step;
  logic [SW-1:0]       w_step_nxt;
  logic                w_load;
  logic [c_CNT_W-1:0]  w_load_val;
  logic                w_tc;
  logic                w_press_nxt;
  logic                w_abort;
  logic [KW-1:0]       w_entry;
  logic [N_KEYS-1:0]   w_auto;
  logic                r_sys_reset_n;
  logic [N_KEYS-1:0]   r_keys;
  logic                r_busy;

  autotype_step_timer #(
    .CW           (c_CNT_W),
    .RST_VAL      ((AUTOSTART != 0) ? (RESET_CYCLES - 1) : 0),
    .PRESS_THRESH (STEP_CYCLES - PRESS_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .load_val  (w_load_val),
    .tc        (w_tc),
    .press_nxt (w_press_nxt)
  );

`ifdef AUTOTYPE_BTN_ABORT_EN
  logic [N_KEYS-1:0] r_btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_q <= '0;
    end else begin
      r_btn_q <= btn;
    end
  end

  assign w_abort = |(btn & ~r_btn_q);
`else
  assign w_abort = 1'b0;
`endif

  // Next-state / step / timer-load logic.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_load      = 1'b0;
    w_load_val  = c_STEP_LOAD;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = RESET_HOLD;
          w_step_nxt  = '0;
          w_load      = 1'b1;
          w_load_val  = c_RESET_LOAD;
        end
      end
      RESET_HOLD: begin
        if (w_abort) begin
          // An abandoned sequence parks step at the last entry, as DONE does.
          w_state_nxt = DONE;
          w_step_nxt  = c_LAST_STEP;
        end else if (w_tc) begin
          w_state_nxt = RUN;
          w_step_nxt  = '0;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (w_abort) begin
          w_state_nxt = DONE;
          w_step_nxt  = c_LAST_STEP;
        end else if (w_tc) begin
          if (r_step == c_LAST_STEP) begin
            w_state_nxt = DONE;
          end else begin
            w_step_nxt = r_step + 1'b1;
            w_load     = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Auto key for the cycle being entered; outputs are registered from the
  // next-state values so they change on the same edge as the state.
  always_comb begin
    w_entry = SEQ[w_step_nxt*KW +: KW];
    w_auto  = '0;
    if ((w_state_nxt == RUN) && w_press_nxt) begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (w_entry == KW'(i + 1)) begin
          w_auto[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_RST_STATE;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_keys        <= '0;
      r_sys_reset_n <= (AUTOSTART == 0);
      r_busy        <= (AUTOSTART != 0);
    end else begin
      r_keys        <= w_auto | btn;
      r_sys_reset_n <= (w_state_nxt != RESET_HOLD);
      r_busy        <= (w_state_nxt == RESET_HOLD) || (w_state_nxt == RUN);
    end
  end

  assign sys_reset_n = r_sys_reset_n;
  assign keys        = r_keys;
  assign busy        = r_busy;
  assign step        = r_step;

endmodule
`default_nettype wire

// File: tb/tb_autotype_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_autotype_sequencer
// Purpose  : Self-checking bench. Two instances share clk/reset/btn:
//            dut_a autostarts, dut_b (AUTOSTART=0) waits for its own start.
//            Expected outputs for the next cycle are pushed when stimulus is
//            driven and popped/compared on the following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_autotype_sequencer;

  localparam int NK = 3;
  localparam int SL = 4;
  localparam int SC = 4;
  localparam int PC = 2;
  localparam int RC = 3;
  // Entries 0..3 = {ENTER, gap, B, C}; entry 0 in the low bits.
  localparam logic [7:0] c_SEQ = 8'b11_10_00_01;

  typedef struct packed {
    logic       srn;
    logic [2:0] keys;
    logic       busy;
    logic [1:0] step;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a;
  logic       start_b;
  logic [2:0] btn;
  logic       srn_a, busy_a, srn_b, busy_b;
  logic [2:0] keys_a, keys_b;
  logic [1:0] step_a, step_b;

  int         seq_tbl [4] = '{1, 0, 2, 3};
  int         t_a, t_b;
  bit         ab_a;
  logic [2:0] bq;
  int         n_tests, n_fail, cyc_no;
  exp_t       sb [$];

  always #5 clk = ~clk;

  autotype_sequencer #(
    .N_KEYS(NK), .SEQ_LEN(SL), .SEQ(c_SEQ), .STEP_CYCLES(SC),
    .PRESS_CYCLES(PC), .RESET_CYCLES(RC), .AUTOSTART(1)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .btn(btn),
    .sys_reset_n(srn_a), .keys(keys_a), .busy(busy_a), .step(step_a)
  );

  autotype_sequencer #(
    .N_KEYS(NK), .SEQ_LEN(SL), .SEQ(c_SEQ), .STEP_CYCLES(SC),
    .PRESS_CYCLES(PC), .RESET_CYCLES(RC), .AUTOSTART(0)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .btn(btn),
    .sys_reset_n(srn_b), .keys(keys_b), .busy(busy_b), .step(step_b)
  );

  // Outputs t cycles after a sequence started (t<0: never started).
  function automatic obs_t exp_out(input int t, input bit ab, input logic [2:0] kb);
    obs_t o;
    int   u, s, c, e;
    o.keys = kb;
    o.srn  = 1'b1;
    o.busy = 1'b0;
    o.step = 2'd0;
    if (ab) begin
      o.step = 2'(SL - 1);
    end else if (t >= 0) begin
      if (t < RC) begin
        o.srn  = 1'b0;
        o.busy = 1'b1;
      end else begin
        u = t - RC;
        s = u / SC;
        c = u % SC;
        if (s >= SL) begin
          o.step = 2'(SL - 1);
        end else begin
          o.busy = 1'b1;
          o.step = 2'(s);
          e = seq_tbl[s];
          if ((c < PC) && (e >= 1) && (e <= NK)) o.keys[e-1] = 1'b1;
        end
      end
    end
    return o;
  endfunction

  function automatic bit is_busy(input int t, input bit ab);
    return !ab && (t >= 0) && (t < RC + SC*SL);
  endfunction

  // Drive this cycle's inputs and push the outputs expected next cycle.
  task automatic drive(input logic [2:0] b, input logic s_a, input logic s_b, input logic r);
    logic [2:0] kb;
    exp_t       x;
    bit         aborting;
    aborting = 1'b0;
    if (r) begin
      t_a  = 0;
      ab_a = 1'b0;
      t_b  = -1;
      kb   = 3'b000;
      bq   = 3'b000;
    end else begin
      kb = b;
`ifdef AUTOTYPE_BTN_ABORT_EN
      aborting = is_busy(t_a, ab_a) && ((b & ~bq) != 3'b000);
`endif
      if (aborting) begin
        ab_a = 1'b1;
      end else if (s_a && !is_busy(t_a, ab_a)) begin
        t_a  = 0;
        ab_a = 1'b0;
      end else if (t_a < 100000) begin
        t_a++;
      end
      if (s_b && !is_busy(t_b, 1'b0)) begin
        t_b = 0;
      end else if ((t_b >= 0) && (t_b < 100000)) begin
        t_b++;
      end
      bq = b;
    end
    x.a = exp_out(t_a, ab_a, kb);
    x.b = exp_out(t_b, 1'b0, kb);
    sb.push_back(x);
    btn     = b;
    start_a = s_a;
    start_b = s_b;
    reset   = r;
  endtask

  task automatic cyc(input logic [2:0] b, input logic s_a, input logic s_b,
                     input logic r, input string tag);
    exp_t x;
    obs_t oa, ob;
    @(negedge clk);
    cyc_no++;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s cyc %0d: scoreboard empty, observed output with no expectation", tag, cyc_no);
    end else begin
      x  = sb.pop_front();
      oa = {srn_a, keys_a, busy_a, step_a};
      ob = {srn_b, keys_b, busy_b, step_b};
      n_tests++;
      assert (oa === x.a) else begin
        n_fail++;
        $error("FAIL %s_a cyc %0d: observed srn/keys/busy/step %b expected %b", tag, cyc_no, oa, x.a);
      end
      n_tests++;
      assert (ob === x.b) else begin
        n_fail++;
        $error("FAIL %s_b cyc %0d: observed srn/keys/busy/step %b expected %b", tag, cyc_no, ob, x.b);
      end
    end
    drive(b, s_a, s_b, r);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc_no  = 0;
    t_a     = 0;
    ab_a    = 1'b0;
    t_b     = -1;
    bq      = 3'b000;
    btn     = 3'b000;
    start_a = 1'b0;
    start_b = 1'b0;
    reset   = 1'b1;

    // Reset applied, then released: sequence cycles 0..21 (done at 19).
    @(negedge clk);
    drive(3'b000, 1'b0, 1'b0, 1'b1);
    repeat (22) cyc(3'b000, 1'b0, 1'b0, 1'b0, "boot");

    // Buttons in DONE: keys follow btn one cycle later, busy stays low.
    repeat (5) cyc(3'b100, 1'b0, 1'b0, 1'b0, "btn_done");
    repeat (3) cyc(3'b000, 1'b0, 1'b0, 1'b0, "btn_release");

    // Restart from DONE; a second start mid-run must be ignored.
    cyc(3'b000, 1'b1, 1'b0, 1'b0, "start_done");
    repeat (9) cyc(3'b000, 1'b0, 1'b0, 1'b0, "replay");
    cyc(3'b000, 1'b1, 1'b0, 1'b0, "start_busy");
    repeat (2) cyc(3'b000, 1'b0, 1'b0, 1'b0, "replay2");

    // Reset during step 2, then full replay.
    cyc(3'b000, 1'b0, 1'b0, 1'b1, "reset_step2");
    repeat (22) cyc(3'b000, 1'b0, 1'b0, 1'b0, "reset_replay");

    // Fresh run, btn[1] rises at sequence cycle 5.
    cyc(3'b000, 1'b1, 1'b0, 1'b0, "start_again");
    repeat (5) cyc(3'b000, 1'b0, 1'b0, 1'b0, "pre_btn");
    repeat (3) cyc(3'b010, 1'b0, 1'b0, 1'b0, "btn_run");
    repeat (16) cyc(3'b000, 1'b0, 1'b0, 1'b0, "post_btn");

    // The non-autostart instance runs only after its own start.
    cyc(3'b000, 1'b0, 1'b1, 1'b0, "start_b");
    repeat (8) cyc(3'b000, 1'b0, 1'b0, 1'b0, "run_b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
